// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default parameters for the fetch path
package fetch_pkg;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_HALT = 2'd1, ST_FAULT = 2'd2} state_t;
  localparam int DEF_PC_W = 32;
  localparam int DEF_IMEM_WORDS = 256;
  localparam int DEF_RESET_PC = 0;
  localparam int DEF_DEPTH = 2;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry prefetch FIFO with synchronous flush
module fetch_queue import fetch_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W = DEF_PC_W + 32
)(
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [W-1:0]               i_data,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  // power-of-two depth lets the pointers wrap on their own
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= r_wr + AW'(1);
      end
      if (i_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  assign o_head = r_mem[r_rd];
  assign o_count = r_cnt;
  assign o_full = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the PC, fetches from instruction memory into a prefetch queue,
// and handles redirect, halt and out-of-range faults.
module fetch_ctrl import fetch_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int PC_W = DEF_PC_W,
  parameter int IMEM_WORDS = DEF_IMEM_WORDS,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
)(
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt,
  output logic            ins_valid,
  output logic [31:0]     ins,
  output logic [PC_W-1:0] ins_pc,
  input  logic            ins_ready,
  output logic            halted,
  output logic            fault,
  output logic [31:0]     fetch_count
);
  localparam int W = PC_W + 32;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [PC_W-1:0] LIMIT = PC_W'(IMEM_WORDS);
  state_t r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0] r_fetch_count;
  logic [W-1:0] r_last;
  logic w_pop, w_push, w_in_range, w_full, w_empty;
  logic [CW-1:0] w_count;
  logic [W-1:0] w_head;
  assign w_in_range = r_pc < LIMIT;
  assign w_pop = ins_valid & ins_ready;
  assign w_push = !redirect && r_state == ST_RUN && !halt && w_in_range && (!w_full || w_pop);
  fetch_queue #(.DEPTH(DEPTH), .W(W)) u_queue (
    .clk     (clk),
    .i_rst_n (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_data  ({imem_data, r_pc}),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  always_comb assert (w_full == (w_count == CW'(DEPTH)));
  // redirect outranks everything; the fault check outranks halt
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= ST_RUN;
      r_pc <= RESET_PC;
      r_fetch_count <= '0;
      r_last <= '0;
    end else begin
      if (ins_valid) r_last <= w_head;
      if (redirect) begin
        r_pc <= redirect_pc;
        r_state <= halt ? ST_HALT : ST_RUN;
      end else begin
        if (w_push) begin
          r_pc <= r_pc + PC_W'(1);
          r_fetch_count <= r_fetch_count + 32'd1;
        end
        case (r_state)
          ST_RUN:  r_state <= !w_in_range ? ST_FAULT : halt ? ST_HALT : ST_RUN;
          ST_HALT: r_state <= halt ? ST_HALT : ST_RUN;
          default: r_state <= ST_FAULT;
        endcase
      end
    end
  assign imem_addr = r_pc;
  assign ins_valid = !w_empty;
  assign {ins, ins_pc} = ins_valid ? w_head : r_last;
  assign halted = r_state == ST_HALT;
  assign fault = r_state == ST_FAULT;
  assign fetch_count = r_fetch_count;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios with a scoreboard of expected accepted PCs
module tb_fetch_ctrl;
  logic clk = 0, rst = 1, redirect = 0, halt = 0, ins_ready = 0;
  logic [31:0] imem_addr, imem_data, redirect_pc = 0, ins, ins_pc, fetch_count;
  logic ins_valid, halted, fault;
  int n_chk = 0, n_pass = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;
  assign imem_data = imem_addr < 32'd256 ? imem_addr * 32'd3 : 32'hBAD0BAD0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc), .ins_ready(ins_ready),
    .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, a, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pcs(int lo, int n);
    for (int i = 0; i < n; i++) sb.push_back(32'(lo + i));
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_valid"}, 32'(ins_valid), 0);
    chk({tag, "_ins"}, ins, 0);
    chk({tag, "_ins_pc"}, ins_pc, 0);
    chk({tag, "_halted"}, 32'(halted), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_fetch_count"}, fetch_count, 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst && ins_valid && ins_ready) begin
          if (sb.size() == 0) chk("unexpected_pop_pc", ins_pc, 32'hFFFFFFFF);
          else begin
            logic [31:0] e;
            e = sb.pop_front();
            chk("pop_pc", ins_pc, e);
            chk("pop_ins", ins, e * 32'd3);
          end
        end
      end
    join_none

    #1 rst = 0;
    #1 chk_reset("reset");
    tick();
    rst = 1;
    // streaming with decode always ready
    ins_ready = 1;
    expect_pcs(0, 4);
    repeat (5) tick();
    chk("stream_fetch_count", fetch_count, 5);
    chk("stream_imem_addr", imem_addr, 5);
    ins_ready = 0;
    chk("stream_sb_drained", 32'(sb.size()), 0);

    // back-pressure: queue fills to DEPTH and PC stalls
    rst = 0;
    #1 chk("midrun_reset_fetch_count", fetch_count, 0);
    rst = 1;
    repeat (6) tick();
    chk("stall_fetch_count", fetch_count, 2);
    chk("stall_imem_addr", imem_addr, 2);
    chk("stall_valid", 32'(ins_valid), 1);
    chk("stall_head_pc", ins_pc, 0);
    expect_pcs(0, 3);
    ins_ready = 1;
    repeat (3) tick();
    ins_ready = 0;
    chk("stall_sb_drained", 32'(sb.size()), 0);
    chk("stall_resume_fetch_count", fetch_count, 5);

    // redirect flushes queued 3,4
    redirect = 1;
    redirect_pc = 100;
    tick();
    redirect = 0;
    chk("redir_valid", 32'(ins_valid), 0);
    chk("redir_imem_addr", imem_addr, 100);
    tick();
    chk("redir_head_valid", 32'(ins_valid), 1);
    chk("redir_head_pc", ins_pc, 100);
    chk("redir_head_ins", ins, 300);
    expect_pcs(100, 2);
    ins_ready = 1;
    repeat (2) tick();
    ins_ready = 0;
    chk("redir_sb_drained", 32'(sb.size()), 0);

    // run off the end of instruction memory
    redirect = 1;
    redirect_pc = 254;
    expect_pcs(254, 2);
    tick();
    redirect = 0;
    ins_ready = 1;
    repeat (4) tick();
    chk("fault_flag", 32'(fault), 1);
    chk("fault_valid", 32'(ins_valid), 0);
    chk("fault_imem_addr", imem_addr, 256);
    chk("fault_halted", 32'(halted), 0);
    chk("fault_fetch_count", fetch_count, 10);
    chk("fault_sb_drained", 32'(sb.size()), 0);
    redirect = 1;
    redirect_pc = 10;
    expect_pcs(10, 1);
    tick();
    redirect = 0;
    chk("fault_cleared", 32'(fault), 0);
    repeat (2) tick();
    ins_ready = 0;
    tick();

    // halt with a full queue: drains, no new fetches, then resumes
    halt = 1;
    tick();
    chk("halt_flag", 32'(halted), 1);
    chk("halt_fetch_count", fetch_count, 13);
    expect_pcs(11, 2);
    ins_ready = 1;
    repeat (2) tick();
    chk("halt_drained_valid", 32'(ins_valid), 0);
    chk("halt_sb_drained", 32'(sb.size()), 0);
    tick();
    chk("halt_frozen_count", fetch_count, 13);
    chk("halt_held_pc", imem_addr, 13);
    halt = 0;
    expect_pcs(13, 1);
    repeat (3) tick();
    ins_ready = 0;
    chk("resume_fetch_count", fetch_count, 15);
    tick();
    halt = 1;
    tick();
    chk("prereset_halted", 32'(halted), 1);
    chk("prereset_valid", 32'(ins_valid), 1);
    chk("prereset_head_pc", ins_pc, 14);
    chk("prereset_fetch_count", fetch_count, 16);

    // asynchronous reset while full and halted
    rst = 0;
    halt = 0;
    #1 chk_reset("async_reset");
    rst = 1;
    tick();
    chk("final_sb_drained", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
